// File: rtl/jt49_bus_arb.sv
// Two-port arbiter and access sequencer for the JT49 PSG register bus (addr/cs_n/wr_n/din/dout).
// Define JT49_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of alternating round-robin.
module jt49_bus_arb #(
   parameter int DEPTH = 4,
   parameter int GAP   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic       req0_wr,
   input  logic [3:0] req0_addr,
   input  logic [7:0] req0_din,
   output logic       rsp0_valid,
   output logic [7:0] rsp0_data,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic       req1_wr,
   input  logic [3:0] req1_addr,
   input  logic [7:0] req1_din,
   output logic       rsp1_valid,
   output logic [7:0] rsp1_data,
   output logic [3:0] psg_addr,
   output logic       psg_cs_n,
   output logic       psg_wr_n,
   output logic [7:0] psg_din,
   input  logic [7:0] psg_dout,
   output logic       busy
);
   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int         CW      = $clog2(DEPTH + 1);
   localparam bit         HAS_GAP = (GAP > 0);
   localparam logic [3:0] GAP_LD  = HAS_GAP ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, GAP_WAIT} state_t;

   state_t           state, state_nx;
   logic [1:0]       req_valid, ready, push, pop, ne, rsp_valid;
   logic [1:0][12:0] req_ent, head;
   logic [1:0][7:0]  rsp_data;
   logic             last_grant, grant;
   logic [3:0]       gap_cnt;

   assign req_valid  = {req1_valid, req0_valid};
   assign req_ent[0] = {req0_wr, req0_addr, req0_din};
   assign req_ent[1] = {req1_wr, req1_addr, req1_din};
   assign req0_ready = ready[0];
   assign req1_ready = ready[1];
   assign rsp0_valid = rsp_valid[0];
   assign rsp1_valid = rsp_valid[1];
   assign rsp0_data  = rsp_data[0];
   assign rsp1_data  = rsp_data[1];
   assign busy       = (state != IDLE) || (|ne);

   // Entry layout {wr, addr, din}; the count register separates full from empty.
   for (genvar p = 0; p < 2; p++) begin : g_fifo
      logic [12:0]   mem [DEPTH];
      logic [AW-1:0] wptr, rptr;
      logic [CW-1:0] cnt;

      assign ne[p]    = (cnt != '0);
      assign ready[p] = rst_n && (cnt != CW'(DEPTH));
      assign push[p]  = req_valid[p] && ready[p];
      assign head[p]  = mem[rptr];

      always_ff @(posedge clk) begin
         if (push[p]) mem[wptr] <= req_ent[p];
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
         end else begin
            if (push[p]) wptr <= wptr + AW'(1);
            if (pop[p])  rptr <= rptr + AW'(1);
            cnt <= cnt + CW'(push[p]) - CW'(pop[p]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      pop      = 2'b00;
      unique case (state)
         IDLE: if (|ne) begin
`ifdef JT49_ARB_FIXED_PRIO_EN
            grant = !ne[0];
`else
            grant = (ne[0] && ne[1]) ? !last_grant : !ne[0];
`endif
            pop      = grant ? 2'b10 : 2'b01;
            state_nx = ACCESS;
         end
         // psg_wr_n still carries the access type during ACCESS
         ACCESS:   state_nx = psg_wr_n ? CAPTURE : (HAS_GAP ? GAP_WAIT : IDLE);
         CAPTURE:  state_nx = HAS_GAP ? GAP_WAIT : IDLE;
         GAP_WAIT: if (gap_cnt == 4'd0) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         gap_cnt    <= 4'd0;
         psg_addr   <= 4'd0;
         psg_din    <= 8'd0;
         psg_cs_n   <= 1'b1;
         psg_wr_n   <= 1'b1;
         rsp_valid  <= 2'b00;
         rsp_data   <= '0;
      end else begin
         rsp_valid <= 2'b00;
         unique case (state)
            IDLE: if (state_nx == ACCESS) begin
               psg_addr   <= head[grant][11:8];
               psg_din    <= head[grant][7:0];
               psg_wr_n   <= !head[grant][12];
               psg_cs_n   <= 1'b0;
               last_grant <= grant;
            end
            ACCESS: begin
               psg_cs_n <= 1'b1;
               psg_wr_n <= 1'b1;
            end
            CAPTURE: begin
               rsp_data[last_grant]  <= psg_dout;
               rsp_valid[last_grant] <= 1'b1;
            end
            default: ;
         endcase
         if (state != GAP_WAIT && state_nx == GAP_WAIT) gap_cnt <= GAP_LD;
         else if (state == GAP_WAIT && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
      end
   end
endmodule

// File: tb/tb_jt49_bus_arb.sv
// Bench for jt49_bus_arb: PSG register model, queue-based arbitration scoreboard, directed and random scenarios.
module tb_jt49_bus_arb;
   localparam int DEPTH = 4;
   localparam int GAP   = 1;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       req0_valid = 1'b0, req0_ready, req0_wr = 1'b0, rsp0_valid;
   logic [3:0] req0_addr = 4'd0;
   logic [7:0] req0_din = 8'd0, rsp0_data;
   logic       req1_valid = 1'b0, req1_ready, req1_wr = 1'b0, rsp1_valid;
   logic [3:0] req1_addr = 4'd0;
   logic [7:0] req1_din = 8'd0, rsp1_data;
   logic [3:0] psg_addr;
   logic       psg_cs_n, psg_wr_n, busy;
   logic [7:0] psg_din;
   logic [7:0] psg_dout = 8'd0;

   jt49_bus_arb #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr), .req0_addr(req0_addr),
      .req0_din(req0_din), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr), .req1_addr(req1_addr),
      .req1_din(req1_din), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
      .psg_addr(psg_addr), .psg_cs_n(psg_cs_n), .psg_wr_n(psg_wr_n), .psg_din(psg_din),
      .psg_dout(psg_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   // PSG: registers written on a write access, dout registered on a read access
   logic [7:0] preg [16] = '{default: 8'h00};
   always @(posedge clk) begin
      if (!psg_cs_n) begin
         if (!psg_wr_n) preg[psg_addr] <= psg_din;
         else           psg_dout       <= preg[psg_addr];
      end
   end

   typedef struct { int e; logic wr; logic [3:0] a; logic [7:0] d; } ent_t;
   typedef struct { int p; logic [7:0] d; } rsp_t;
   ent_t q0[$], q1[$];
   rsp_t xr[$];
   int   glog[$], gedge[$];
   int   ecnt = 0, n_cmp = 0, n_bad = 0;

   initial forever begin
      @(posedge clk);
      ecnt++;
   end

   // Scoreboard: each entry carries the edge it was pushed on; a grant may only take
   // entries pushed before the grant edge. Tie rule applied from the last granted port.
   initial begin
      int   last_p, prev_g, p;
      bit   prev_rd, prev_cs, e0, e1;
      ent_t x;
      rsp_t r;
      last_p = 1; prev_g = -100; prev_rd = 0; prev_cs = 1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q0.delete(); q1.delete(); xr.delete();
            last_p = 1; prev_g = -100; prev_cs = 1;
         end else begin
            n_cmp++;
            if (!psg_wr_n && psg_cs_n) begin
               n_bad++; $display("FAIL wr_n_alone: wr_n=%b cs_n=%b required wr_n=1", psg_wr_n, psg_cs_n);
            end
            if (!psg_cs_n) begin
               n_cmp++;
               if (!prev_cs) begin
                  n_bad++; $display("FAIL cs_width: cs_n low in two consecutive cycles at edge %0d", ecnt);
               end
               e0 = q0.size() > 0 && q0[0].e < ecnt;
               e1 = q1.size() > 0 && q1[0].e < ecnt;
               n_cmp++;
               if (!e0 && !e1) begin
                  n_bad++; $display("FAIL spurious_grant: access addr=%h with no queued entry", psg_addr);
               end else begin
`ifdef JT49_ARB_FIXED_PRIO_EN
                  p = e0 ? 0 : 1;
`else
                  p = (e0 && e1) ? 1 - last_p : (e0 ? 0 : 1);
`endif
                  if (p == 0) x = q0.pop_front();
                  else        x = q1.pop_front();
                  if ({psg_wr_n, psg_addr, psg_din} !== {~x.wr, x.a, x.d}) begin
                     n_bad++;
                     $display("FAIL grant_entry: got wr_n=%b addr=%h din=%h, required port%0d wr_n=%b addr=%h din=%h",
                              psg_wr_n, psg_addr, psg_din, p, ~x.wr, x.a, x.d);
                  end
                  if (!x.wr) xr.push_back('{p, preg[x.a]});
                  n_cmp++;
                  if (ecnt - prev_g < (prev_rd ? 3 : 2) + GAP) begin
                     n_bad++; $display("FAIL spacing: grant %0d edges after previous, required >= %0d",
                                       ecnt - prev_g, (prev_rd ? 3 : 2) + GAP);
                  end
                  last_p = p; prev_g = ecnt; prev_rd = !x.wr;
                  glog.push_back(p); gedge.push_back(ecnt);
               end
            end
            prev_cs = psg_cs_n;
            if (rsp0_valid || rsp1_valid) begin
               n_cmp++;
               if (xr.size() == 0) begin
                  n_bad++; $display("FAIL unexpected_rsp: rsp0_valid=%b rsp1_valid=%b, none expected", rsp0_valid, rsp1_valid);
               end else begin
                  r = xr.pop_front();
                  if (rsp0_valid !== (r.p == 0) || rsp1_valid !== (r.p == 1) ||
                      ((r.p == 0) ? rsp0_data : rsp1_data) !== r.d) begin
                     n_bad++; $display("FAIL rsp: v0=%b d0=%h v1=%b d1=%h, required port%0d data=%h",
                                       rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, r.p, r.d);
                  end
               end
            end
            n_cmp++;
            if (req0_ready !== (q0.size() < DEPTH) || req1_ready !== (q1.size() < DEPTH)) begin
               n_bad++; $display("FAIL ready: got %b%b, required %b%b", req1_ready, req0_ready,
                                 q1.size() < DEPTH, q0.size() < DEPTH);
            end
            if (req0_valid && req0_ready) q0.push_back('{ecnt + 1, req0_wr, req0_addr, req0_din});
            if (req1_valid && req1_ready) q1.push_back('{ecnt + 1, req1_wr, req1_addr, req1_din});
         end
      end
   end

   // Holds each valid until accepted; returns #1 after the last push edge.
   task automatic drive2(input bit v0, input logic [12:0] e0, input bit v1, input logic [12:0] e1);
      bit p0, p1;
      int t;
      p0 = v0; p1 = v1; t = 0;
      {req0_wr, req0_addr, req0_din} = e0;
      {req1_wr, req1_addr, req1_din} = e1;
      req0_valid = p0; req1_valid = p1;
      while ((p0 || p1) && t < 64) begin
         @(negedge clk);
         if (req0_ready) p0 = 0;
         if (req1_ready) p1 = 0;
         @(posedge clk); #1;
         req0_valid = p0; req1_valid = p1;
         t++;
      end
      n_cmp++;
      if (p0 || p1) begin
         n_bad++; $display("FAIL drive_timeout: pending p0=%b p1=%b, required accepted", p0, p1);
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      do begin @(negedge clk); t++; end
      while ((busy || q0.size() != 0 || q1.size() != 0 || xr.size() != 0) && t < 400);
      n_cmp++;
      if (busy !== 1'b0 || q0.size() != 0 || q1.size() != 0 || xr.size() != 0) begin
         n_bad++; $display("FAIL idle_%s: busy=%b pending q0=%0d q1=%0d rsp=%0d, required all 0",
                           tag, busy, q0.size(), q1.size(), xr.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({psg_cs_n, psg_wr_n, psg_addr, psg_din} !== {1'b1, 1'b1, 4'd0, 8'd0}) begin
         n_bad++; $display("FAIL reset_psg: cs_n=%b wr_n=%b addr=%h din=%h, required 1 1 0 00",
                           psg_cs_n, psg_wr_n, psg_addr, psg_din);
      end
      n_cmp++;
      if ({rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, busy} !== 19'd0) begin
         n_bad++; $display("FAIL reset_rsp: v=%b%b d0=%h d1=%h busy=%b, required all 0",
                           rsp1_valid, rsp0_valid, rsp0_data, rsp1_data, busy);
      end
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         n_bad++; $display("FAIL reset_ready: got %b%b, required 00", req1_ready, req0_ready);
      end
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic test_write;
      drive2(1, {1'b1, 4'd7, 8'h38}, 0, 13'd0);
      @(negedge clk);
      n_cmp++;
      if (psg_cs_n !== 1'b1) begin
         n_bad++; $display("FAIL write_early: cs_n=%b one cycle after push, required 1", psg_cs_n);
      end
      @(negedge clk);
      n_cmp++;
      if ({psg_cs_n, psg_wr_n, psg_addr, psg_din} !== {1'b0, 1'b0, 4'd7, 8'h38}) begin
         n_bad++; $display("FAIL write_access: cs_n=%b wr_n=%b addr=%h din=%h, required 0 0 7 38",
                           psg_cs_n, psg_wr_n, psg_addr, psg_din);
      end
      @(negedge clk);
      n_cmp++;
      if ({psg_cs_n, psg_wr_n, psg_addr, psg_din} !== {1'b1, 1'b1, 4'd7, 8'h38}) begin
         n_bad++; $display("FAIL write_release: cs_n=%b wr_n=%b addr=%h din=%h, required 1 1 7 38",
                           psg_cs_n, psg_wr_n, psg_addr, psg_din);
      end
      @(posedge clk); #1;
      wait_idle("write");
   endtask

   task automatic test_read;
      drive2(1, {1'b1, 4'd8, 8'hA5}, 0, 13'd0);
      wait_idle("read_setup");
      drive2(0, 13'd0, 1, {1'b0, 4'd8, 8'h5A});
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({psg_cs_n, psg_wr_n, psg_addr} !== {1'b0, 1'b1, 4'd8}) begin
         n_bad++; $display("FAIL read_access: cs_n=%b wr_n=%b addr=%h, required 0 1 8", psg_cs_n, psg_wr_n, psg_addr);
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
         n_bad++; $display("FAIL read_early: rsp v0=%b v1=%b, required 00", rsp0_valid, rsp1_valid);
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp0_valid, rsp1_valid, rsp1_data} !== {1'b0, 1'b1, 8'hA5}) begin
         n_bad++; $display("FAIL read_rsp: v0=%b v1=%b d1=%h, required 0 1 a5", rsp0_valid, rsp1_valid, rsp1_data);
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp1_valid, rsp1_data} !== {1'b0, 8'hA5}) begin
         n_bad++; $display("FAIL read_pulse: v1=%b d1=%h, required 0 a5 (held)", rsp1_valid, rsp1_data);
      end
      @(posedge clk); #1;
      wait_idle("read");
   endtask

   task automatic test_contention;
`ifdef JT49_ARB_FIXED_PRIO_EN
      int exp_o [6] = '{0, 0, 0, 1, 1, 1};
`else
      int exp_o [6] = '{0, 1, 0, 1, 0, 1};
`endif
      glog.delete(); gedge.delete();
      for (int i = 0; i < 3; i++)
         drive2(1, {1'b1, 4'(i), 8'($urandom)}, 1, {1'b1, 4'(8 + i), 8'($urandom)});
      wait_idle("contention");
      n_cmp++;
      if (glog.size() != 6) begin
         n_bad++; $display("FAIL contention_count: %0d grants, required 6", glog.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (glog[i] != exp_o[i]) begin
               n_bad++; $display("FAIL contention_order: grant %0d to port%0d, required port%0d", i, glog[i], exp_o[i]);
            end
            if (i > 0) begin
               n_cmp++;
               if (gedge[i] - gedge[i-1] != 2 + GAP) begin
                  n_bad++; $display("FAIL contention_gap: spacing %0d, required %0d", gedge[i] - gedge[i-1], 2 + GAP);
               end
            end
         end
      end
   endtask

   task automatic test_two_each;
`ifdef JT49_ARB_FIXED_PRIO_EN
      int exp_o [4] = '{0, 0, 1, 1};
`else
      int exp_o [4] = '{0, 1, 0, 1};
`endif
      glog.delete(); gedge.delete();
      for (int i = 0; i < 2; i++)
         drive2(1, {1'b1, 4'(2 + i), 8'($urandom)}, 1, {1'b1, 4'(12 + i), 8'($urandom)});
      wait_idle("two_each");
      n_cmp++;
      if (glog.size() != 4) begin
         n_bad++; $display("FAIL two_each_count: %0d grants, required 4", glog.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (glog[i] != exp_o[i]) begin
               n_bad++; $display("FAIL two_each_order: grant %0d to port%0d, required port%0d", i, glog[i], exp_o[i]);
            end
         end
      end
   endtask

   task automatic test_full;
      int stall_at, t;
      bit acc;
      stall_at = -1;
      drive2(0, 13'd0, 1, {1'b0, 4'd2, 8'h00});
      for (int k = 0; k < 5; k++) begin
         req0_valid = 1;
         {req0_wr, req0_addr, req0_din} = {1'b1, 4'(k + 1), 8'($urandom)};
         acc = 0; t = 0;
         while (!acc && t < 32) begin
            @(negedge clk);
            if (req0_ready) acc = 1;
            else if (stall_at < 0) stall_at = k;
            @(posedge clk); #1;
            t++;
         end
      end
      req0_valid = 0;
      n_cmp++;
      if (stall_at != 4) begin
         n_bad++; $display("FAIL full_stall: first refused entry %0d, required 4", stall_at);
      end
      wait_idle("full");
   endtask

   task automatic test_reset_mid;
      drive2(1, {1'b0, 4'd3, 8'h00}, 1, {1'b1, 4'd4, 8'h11});
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 0;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            n_bad++; $display("FAIL reset_mid_rsp: v0=%b v1=%b, required 00", rsp0_valid, rsp1_valid);
         end
      end
      n_cmp++;
      if ({psg_cs_n, busy} !== 2'b10) begin
         n_bad++; $display("FAIL reset_mid_state: cs_n=%b busy=%b, required 1 0", psg_cs_n, busy);
      end
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      n_cmp++;
      if ({req0_ready, req1_ready, busy} !== 3'b110) begin
         n_bad++; $display("FAIL reset_mid_empty: ready=%b%b busy=%b, required 11 0", req1_ready, req0_ready, busy);
      end
      @(posedge clk); #1;
      glog.delete(); gedge.delete();
      drive2(1, {1'b1, 4'd5, 8'h21}, 1, {1'b1, 4'd6, 8'h22});
      wait_idle("reset_mid");
      n_cmp++;
      if (glog.size() == 0 || glog[0] != 0) begin
         n_bad++; $display("FAIL reset_mid_first: first grant port%0d (n=%0d), required port0",
                           (glog.size() != 0) ? glog[0] : -1, glog.size());
      end
   endtask

   task automatic test_random;
      for (int c = 0; c < 400; c++) begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         {req0_wr, req0_addr, req0_din} = 13'($urandom);
         {req1_wr, req1_addr, req1_din} = 13'($urandom);
         @(posedge clk); #1;
      end
      req0_valid = 0; req1_valid = 0;
      wait_idle("random");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_contention();
      test_two_each();
      test_full();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
